// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Imported by the arbiter top and its shifter sub-module.
package shift_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_SLL = 1'b0,
        OP_SRL = 1'b1
    } op_t;

endpackage

// File: rtl/shift_left_logical.sv
// Logarithmic barrel shifter, logical left shift with zero fill.
// Stage s shifts by 2**s when shamt bit s is set.
module shift_left_logical #(
    parameter int N = 32,
    parameter int L = $clog2(N)
) (
    input  logic [N-1:0] i_data,
    input  logic [L-1:0] i_shamt,
    output logic [N-1:0] o_data
);

    logic [N-1:0] w_stage [0:L];

    assign w_stage[0] = i_data;

    for (genvar s = 0; s < L; s++) begin : g_stage
        localparam int SH = 1 << s;
        // Conditionally shift the previous stage by this stage's weight
        assign w_stage[s+1] = i_shamt[s]
            ? {w_stage[s][N-1-SH:0], {SH{1'b0}}}
            : w_stage[s];
    end

    assign o_data = w_stage[L];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter and sequencer for the shared 32-bit shifter.
// SRL is produced by bit-reversing around the left shifter.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int N = 32,
    parameter int L = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_data,
    input  logic [NUM_REQ*L-1:0] req_shamt,
    input  logic [NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]   resp_valid,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic [N-1:0]         resp_data
);

    state_t              r_state;
    logic                r_last;
    logic                r_owner;
    logic [N-1:0]        r_data;
    logic [L-1:0]        r_shamt;
    op_t                 r_op;
    logic [N-1:0]        r_result;
    logic [NUM_REQ-1:0]  r_resp_valid;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_win;
    logic                w_accept;
    logic [N-1:0]        w_sel_data;
    logic [L-1:0]        w_sel_shamt;
    op_t                 w_sel_op;
    logic [N-1:0]        w_rev_in;
    logic [N-1:0]        w_sh_in;
    logic [N-1:0]        w_sh_out;
    logic [N-1:0]        w_rev_out;
    logic [N-1:0]        w_result;

    // Grant one-hot in idle; a tie goes to the requester not served last
    always_comb begin
        w_grant = '0;
        if (!rst && r_state == S_IDLE) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign req_ready   = w_grant;
    assign w_win       = w_grant[1];
    assign w_accept    = |w_grant;
    assign w_sel_data  = req_data[N*w_win +: N];
    assign w_sel_shamt = req_shamt[L*w_win +: L];
    assign w_sel_op    = op_t'(req_op[w_win]);

    for (genvar i = 0; i < N; i++) begin : g_rev
        assign w_rev_in[i]  = r_data[N-1-i];
        assign w_rev_out[i] = w_sh_out[N-1-i];
    end

    assign w_sh_in = (r_op == OP_SRL) ? w_rev_in : r_data;

    shift_left_logical #(
        .N (N),
        .L (L)
    ) u_sll (
        .i_data  (w_sh_in),
        .i_shamt (r_shamt),
        .o_data  (w_sh_out)
    );

    assign w_result = (r_op == OP_SRL) ? w_rev_out : w_sh_out;

    // Transaction sequencer: accept, shift, then hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_data       <= '0;
            r_shamt      <= '0;
            r_op         <= OP_SLL;
            r_result     <= '0;
            r_resp_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_data  <= w_sel_data;
                        r_shamt <= w_sel_shamt;
                        r_op    <= w_sel_op;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result     <= w_result;
                    r_resp_valid <= {r_owner, ~r_owner};
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready[r_owner]) begin
                        r_resp_valid <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= '0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_result;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: drivers push expected results,
// a negedge monitor pops and compares on each response handshake.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_data;
    logic [9:0]  req_shamt;
    logic [1:0]  req_op;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_data;

    logic [1:0]  rr_manual;
    logic [1:0]  rr_random;
    bit          rr_rand;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc;
    int          cur_owner;
    logic [1:0]  prev_rv;
    logic [31:0] exp_q [2][$];
    int          grant_log[$];

    shift_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign resp_ready = rr_rand ? rr_random : rr_manual;

    always @(posedge clk) begin
        #1;
        rr_random = 2'($urandom_range(0, 3));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(logic [31:0] d,
                                              logic [4:0] sh,
                                              logic op);
        return op ? (d >> sh) : (d << sh);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_rv = 2'b00;
        end else begin
            if (resp_valid != 2'b00) begin
                chk("resp_owner", 32'(resp_valid), 32'(2'b01 << cur_owner));
                if (prev_rv == 2'b00)
                    chk("latency", 32'(cyc + 1 - acc_cyc), 32'd2);
                for (int k = 0; k < 2; k++) begin
                    if (resp_valid[k] && resp_ready[k]) begin
                        if (exp_q[k].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_resp r%0d: got %h expected none",
                                     k, resp_data);
                        end else begin
                            chk($sformatf("resp_data_r%0d", k), resp_data,
                                exp_q[k].pop_front());
                        end
                    end
                end
            end
            prev_rv = resp_valid;
        end
    end

    task automatic issue(int k, logic [31:0] d, logic [4:0] sh,
                         logic op, logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        req_data[32*k +: 32] = d;
        req_shamt[5*k +: 5]  = sh;
        req_op[k]            = op;
        req_valid[k]         = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (!rst && req_ready[k]) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout r%0d: got no grant expected grant", k);
            req_valid[k] = 1'b0;
        end else begin
            exp_q[k].push_back(exp);
            grant_log.push_back(k);
            cur_owner = k;
            acc_cyc   = cyc + 1;
            @(posedge clk);
            #1;
            req_valid[k]         = 1'b0;
            req_data[32*k +: 32] = ~d;
            req_shamt[5*k +: 5]  = ~sh;
            req_op[k]            = ~op;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size()) > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q[0].delete();
        exp_q[1].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_stream(int k, int n);
        logic [31:0] d;
        logic [4:0]  sh;
        logic        op;
        int          g;
        for (int i = 0; i < n; i++) begin
            d  = $urandom;
            sh = 5'($urandom_range(0, 31));
            op = 1'($urandom_range(0, 1));
            g  = $urandom_range(0, 3);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            issue(k, d, sh, op, ref_shift(d, sh, op));
        end
    endtask

    task automatic reset_mid(bit in_resp);
        rr_manual = 2'b00;
        issue(1, 32'hA5A5_0001, 5'd1, OP_SLL, 32'h4B4A_0002);
        if (in_resp) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("resp_before_rst", 32'(resp_valid), 32'h2);
            @(posedge clk);
            #1;
        end
        exp_q[1].delete();
        rst       = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("ready_in_rst", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_tie_grant", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        rr_manual = 2'b11;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_data  = '0;
        req_shamt = '0;
        req_op    = '0;
        rr_manual = 2'b11;
        rr_rand   = 1'b0;
        cur_owner = 0;
        acc_cyc   = 0;
        prev_rv   = 2'b00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_resp_valid", 32'(resp_valid), 32'h0);
        chk("reset_resp_data", resp_data, 32'h0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(0, 32'h0000_00F1, 5'd4, OP_SLL, 32'h0000_0F10);
        drain();
        issue(1, 32'h8000_0001, 5'd31, OP_SRL, 32'h0000_0001);
        issue(1, 32'h8000_0001, 5'd0, OP_SRL, 32'h8000_0001);
        issue(0, 32'hFFFF_FFFF, 5'd31, OP_SLL, 32'h8000_0000);
        issue(0, 32'h1234_5678, 5'd0, OP_SLL, 32'h1234_5678);
        issue(1, 32'hF000_0000, 5'd4, OP_SRL, 32'h0F00_0000);
        issue(1, 32'hFFFF_FFFF, 5'd31, OP_SRL, 32'h0000_0001);
        drain();

        do_reset();
        grant_log.delete();
        fork
            begin
                issue(0, 32'h0000_0001, 5'd1, OP_SLL, 32'h0000_0002);
                issue(0, 32'h0000_0003, 5'd2, OP_SLL, 32'h0000_000C);
            end
            begin
                issue(1, 32'h0000_0080, 5'd3, OP_SRL, 32'h0000_0010);
                issue(1, 32'h0000_FF00, 5'd8, OP_SRL, 32'h0000_00FF);
            end
        join
        drain();
        chk("tie_grant_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("tie_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

        rr_manual = 2'b10;
        issue(0, 32'h1234_5678, 5'd8, OP_SLL, 32'h3456_7800);
        fork
            issue(1, 32'h0000_FFFF, 5'd16, OP_SLL, 32'hFFFF_0000);
        join_none
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(resp_valid), 32'h1);
            chk("bp_resp_data", resp_data, 32'h3456_7800);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            rr_manual[1] = ~rr_manual[1];
        end
        rr_manual = 2'b11;
        wait fork;
        drain();

        reset_mid(1'b0);
        reset_mid(1'b1);

        rr_rand = 1'b1;
        fork
            rand_stream(0, 500);
            rand_stream(1, 500);
        join
        drain();
        rr_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester arbiter and sequencer for the shared 32-bit logical shift unit. Accepts shift requests from two clients over valid/ready handshakes, grants the single shifter round-robin, performs SLL directly or SRL by bit-reversal around the left shifter, and returns a registered result to the granted client. It sits between the ALU-side issue logic and the shared shifter in the datapath.

## Interface

- N, 32, data width; only N = 32 is supported.
- L, $clog2(N) = 5, shift-amount width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit k is requester k.
- req_ready  output  2  per-requester acceptance; a request is accepted on an edge where req_valid[k] & req_ready[k].
- req_data  input  2*N  operands; requester k uses [N*(k+1)-1:N*k].
- req_shamt  input  2*L  shift amounts; requester k uses [L*(k+1)-1:L*k].
- req_op  input  2  per-requester op: 0 = SLL, 1 = SRL (zero fill).
- resp_valid  output  2  result valid, asserted only for the requester that owns the current transaction.
- resp_ready  input  2  per-requester result acceptance.
- resp_data  output  N  shared result bus; meaningful only while some resp_valid bit is high.

## Operation

- One transaction in flight at a time; FSM states S_IDLE, S_EXEC, S_RESP.
- S_IDLE: arbitrate. If exactly one req_valid is high, that requester wins. If both are high, the winner is the requester not granted last (round-robin pointer `last`). req_ready is one-hot for the winner; 0 when no request is pending. On acceptance latch owner id, operand, shamt and op; update `last` to the owner; go to S_EXEC.
- S_EXEC: the shifter is driven from the latched operands. SLL: out = in << shamt. SRL: out = rev(rev(in) << shamt), where rev reverses bit order. Result registered into resp_data; go to S_RESP. req_ready = 0.
- S_RESP: resp_valid[owner] = 1, resp_data stable. On resp_ready[owner] go to S_IDLE. resp_ready of the non-owner is ignored. req_ready = 0.
- shamt = 0 returns the operand unchanged for both ops; shamt = 31 leaves only one surviving bit (bit 0 for SLL, bit 31 for SRL).
- Requests are not dropped: a losing or stalled requester keeps req_valid high and is served next; requester inputs need not be stable after acceptance.
- rst: state to S_IDLE, `last` to 1 (requester 0 wins the first tie), resp_data to 0, latched operands to 0. Reset in S_EXEC or S_RESP abandons the transaction with no response.

## Timing

- Reset values: req_ready = 2'b00 during the rst cycle, resp_valid = 2'b00, resp_data = 0.
- req_ready is combinational from req_valid and state (Mealy) in S_IDLE only; resp_valid and resp_data are registered/state-decoded.
- Latency: request accepted at edge t -> resp_valid high from edge t+2.
- Minimum issue interval 3 cycles: accept at t, result at t+2, response taken at t+2 edge if resp_ready already high, next accept at edge t+3.
- Simultaneous resp handshake and new req_valid: no acceptance until back in S_IDLE (no bypass).

## Structure

- Package shift_arbiter_pkg: state enum (S_IDLE, S_EXEC, S_RESP), op enum (OP_SLL = 0, OP_SRL = 1), requester-count constant 2.
- One sub-module: the codebase's shift_left_logical (N = 32), instantiated once; bit reversal done with a generate loop or function in this block.
- Round-robin grant logic kept inline; no separate arbiter module.

## Test plan

- Reset then single request: requester 0, data 0x0000_00F1, shamt 4, SLL -> resp_valid = 2'b01 two cycles after accept, resp_data 0x0000_0F10.
- SRL path: requester 1, data 0x8000_0001, shamt 31 -> resp_data 0x0000_0001; shamt 0 -> 0x8000_0001; SLL shamt 31 on 0xFFFF_FFFF -> 0x8000_0000.
- Tie and fairness: both requesters valid continuously after reset -> grants 0,1,0,1; each sees exactly one response per grant, resp_valid never to the non-owner.
- Response backpressure: hold resp_ready[owner] low 5 cycles -> resp_valid and resp_data stable, req_ready = 0 throughout, non-owner resp_ready toggling has no effect.
- Reset mid-operation: assert rst in S_EXEC and in S_RESP -> next cycle all outputs at reset values, no stale response, next tie goes to requester 0.
- Random regression: 1000 random requests with random valid/ready stalls -> each result matches the reference model (in << shamt or in >> shamt), per-requester order preserved, no lost requests.
